irq_source_ctrl: RTL and testbench

- Interrupt request generator that drives the single-line external interrupt input of the CP0 block.
- Collects edge-triggered device interrupt lines into a pending register and applies a mask.
- Raises a held, level request toward CP0, then sequences claim and ERET acknowledge from the handler.
- Sits between peripherals and the CPU. The handler accesses it through a small register port on the data bus.

---
 rtl/irq_source_ctrl.sv | 151 +++++++++++++++
 tb/tb_irq_source_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_source_ctrl.sv
// Edge-triggered interrupt collector with mask, lowest-index priority and a
// REQ/SERVICE handshake that drives the single level interrupt input of CP0.
`timescale 1ns/1ps

module irq_source_ctrl #(
  parameter int N_SRC    = 8,
  parameter int MIN_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             eret,
  input  logic [1:0]       bus_addr,
  input  logic             bus_we,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             ir_out,
  output logic [3:0]       cur_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_MASK    = 2'd1;
  localparam logic [1:0] A_CLAIM   = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  localparam int             HW        = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MIN_HOLD - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(MIN_HOLD);

  logic [N_SRC-1:0] src_q, src_qq;
  logic [N_SRC-1:0] pending, mask;
  logic [N_SRC-1:0] rise, active, claim_clr;
  logic [3:0]       sel_id;
  logic             claim_wr;
  logic             claim_seen;
  logic [HW-1:0]    hold_cnt;
  state_t           state;
  logic             unused_wdata;

  assign rise         = src_q & ~src_qq;
  assign active       = pending & mask;
  assign claim_wr     = bus_we && (bus_addr == A_CLAIM);
  assign unused_wdata = ^bus_wdata;

  // Out-of-range claim ids match no bit and therefore clear nothing.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < N_SRC; i++)
      if (claim_wr && (bus_wdata[3:0] == 4'(i)))
        claim_clr[i] = 1'b1;
  end

  // Descending scan: the last hit is the lowest index, i.e. highest priority.
  always_comb begin
    sel_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[i])
        sel_id = 4'(i);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= '0;
      src_qq  <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      src_q   <= src_irq;
      src_qq  <= src_q;
      pending <= (pending & ~claim_clr) | rise;  // a same-cycle set beats the clear
      if (bus_we && (bus_addr == A_MASK))
        mask <= bus_wdata[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ir_out     <= 1'b0;
      cur_id     <= '0;
      hold_cnt   <= '0;
      claim_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ir_out <= 1'b0;
          if (|active) begin
            state    <= REQ;
            ir_out   <= 1'b1;
            cur_id   <= sel_id;
            hold_cnt <= '0;
          end
        end
        REQ: begin
          if (hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + HW'(1);
          if (claim_wr)
            claim_seen <= 1'b1;
          // CP0 needs the line high for MIN_HOLD cycles before we may drop it.
          if (hold_cnt >= HOLD_LAST) begin
            if (claim_seen || claim_wr) begin
              state      <= SERVICE;
              ir_out     <= 1'b0;
              claim_seen <= 1'b0;
            end else if (eret) begin
              state  <= IDLE;
              ir_out <= 1'b0;
            end
          end
        end
        SERVICE: begin
          ir_out <= 1'b0;
          if (eret)
            state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          ir_out <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      A_PENDING: bus_rdata[N_SRC-1:0] = pending;
      A_MASK:    bus_rdata[N_SRC-1:0] = mask;
      A_CLAIM: begin
        bus_rdata[31]  = |active;
        bus_rdata[3:0] = sel_id;
      end
      A_STATUS: begin
        bus_rdata[15:12] = cur_id;
        bus_rdata[4]     = claim_seen;
        bus_rdata[1:0]   = state;
      end
      default: bus_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Bench for irq_source_ctrl: a cycle table for request/claim/eret timing plus
// directed sequences for priority, eret corners, set-vs-clear and reset.
`timescale 1ns/1ps

module tb_irq_source_ctrl;

  localparam int N_SRC = 8;
  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_MASK    = 2'd1;
  localparam logic [1:0] A_CLAIM   = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] src_irq;
  logic             eret;
  logic [1:0]       bus_addr;
  logic             bus_we;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;
  logic             ir_out;
  logic [3:0]       cur_id;

  always #5 clk = ~clk;

  irq_source_ctrl #(.N_SRC(N_SRC), .MIN_HOLD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_irq   (src_irq),
    .eret      (eret),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .ir_out    (ir_out),
    .cur_id    (cur_id)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic [7:0]  src;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic        exp_ir;
    logic [3:0]  exp_id;
    logic [31:0] exp_status;
    logic [31:0] exp_pend;
    logic [31:0] exp_claim;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[15];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_miss++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    sb_push(name, exp);
    sb_pop(act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [31:0] data);
    bus_we   = 1'b0;
    bus_addr = addr;
    #1;
    data = bus_rdata;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    step();
    bus_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;

    rst = 1'b1; src_irq = '0; eret = 1'b0;
    bus_addr = '0; bus_we = 1'b0; bus_wdata = '0;
    step();
    step();
    rst = 1'b0;

    check("reset ir_out", {31'b0, ir_out}, 32'd0);
    check("reset cur_id", {28'b0, cur_id}, 32'd0);
    rd(A_STATUS, r);  check("reset status", r, 32'd0);
    rd(A_PENDING, r); check("reset pending", r, 32'd0);
    rd(A_MASK, r);    check("reset mask", r, 32'd0);

    // Per-cycle table: inputs for the next edge, expected state after it.
    //           src    we    addr      wdata  eret  ir    id    status       pend   claim
    tbl[0]  = '{8'h00, 1'b1, A_MASK,  32'h1, 1'b0, 1'b0, 4'd0, 32'h00,     32'h0, 32'h0};
    tbl[1]  = '{8'h01, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b0, 4'd0, 32'h00,   32'h0, 32'h0};
    tbl[2]  = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b0, 4'd0, 32'h00,   32'h1, 32'h80000000};
    tbl[3]  = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b1, 4'd0, 32'h01,   32'h1, 32'h80000000};
    tbl[4]  = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b1, 4'd0, 32'h01,   32'h1, 32'h80000000};
    tbl[5]  = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b1, 4'd0, 32'h01,   32'h1, 32'h80000000};
    tbl[6]  = '{8'h00, 1'b1, A_CLAIM, 32'h0, 1'b0, 1'b0, 4'd0, 32'h02,     32'h0, 32'h0};
    tbl[7]  = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b1, 1'b0, 4'd0, 32'h00,   32'h0, 32'h0};
    tbl[8]  = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b0, 4'd0, 32'h00,   32'h0, 32'h0};
    tbl[9]  = '{8'h01, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b0, 4'd0, 32'h00,   32'h0, 32'h0};
    tbl[10] = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b0, 4'd0, 32'h00,   32'h1, 32'h80000000};
    tbl[11] = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b1, 4'd0, 32'h01,   32'h1, 32'h80000000};
    tbl[12] = '{8'h00, 1'b1, A_CLAIM, 32'h0, 1'b0, 1'b1, 4'd0, 32'h11,     32'h0, 32'h0};
    tbl[13] = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b0, 1'b0, 4'd0, 32'h02,   32'h0, 32'h0};
    tbl[14] = '{8'h00, 1'b0, A_PENDING, 32'h0, 1'b1, 1'b0, 4'd0, 32'h00,   32'h0, 32'h0};

    for (int i = 0; i < 15; i++) begin
      src_irq   = tbl[i].src;
      bus_we    = tbl[i].we;
      bus_addr  = tbl[i].addr;
      bus_wdata = tbl[i].wdata;
      eret      = tbl[i].eret;
      sb_push($sformatf("v%0d ir_out", i), {31'b0, tbl[i].exp_ir});
      sb_push($sformatf("v%0d cur_id", i), {28'b0, tbl[i].exp_id});
      sb_push($sformatf("v%0d status", i), tbl[i].exp_status);
      sb_push($sformatf("v%0d pending", i), tbl[i].exp_pend);
      sb_push($sformatf("v%0d claim", i), tbl[i].exp_claim);
      step();
      bus_we = 1'b0;
      eret   = 1'b0;
      sb_pop({31'b0, ir_out});
      sb_pop({28'b0, cur_id});
      rd(A_STATUS, r);  sb_pop(r);
      rd(A_PENDING, r); sb_pop(r);
      rd(A_CLAIM, r);   sb_pop(r);
    end

    // Two simultaneous sources: lowest index first, the other follows.
    do_reset();
    wr(A_MASK, 32'hFF);
    src_irq = 8'h24; step();
    src_irq = 8'h00; step();
    step();
    check("prio ir_out", {31'b0, ir_out}, 32'd1);
    check("prio cur_id", {28'b0, cur_id}, 32'd2);
    rd(A_CLAIM, r);   check("prio claim read", r, 32'h80000002);
    rd(A_PENDING, r); check("prio pending", r, 32'h24);
    wr(A_CLAIM, 32'd2);
    rd(A_STATUS, r);  check("prio claim_seen", r, 32'h2011);
    step();
    check("prio service ir", {31'b0, ir_out}, 32'd0);
    rd(A_STATUS, r);  check("prio service status", r, 32'h2002);
    eret = 1'b1; step(); eret = 1'b0;
    rd(A_STATUS, r);  check("prio idle status", r, 32'h2000);
    step();
    check("prio second ir", {31'b0, ir_out}, 32'd1);
    check("prio second id", {28'b0, cur_id}, 32'd5);

    // eret before the hold is ignored; after it, returns to IDLE and re-raises.
    eret = 1'b1; step();
    check("early eret ir", {31'b0, ir_out}, 32'd1);
    rd(A_STATUS, r);  check("early eret status", r, 32'h5001);
    eret = 1'b1; step(); eret = 1'b0;
    check("late eret ir", {31'b0, ir_out}, 32'd0);
    rd(A_STATUS, r);  check("late eret status", r, 32'h5000);
    step();
    check("reraise ir", {31'b0, ir_out}, 32'd1);
    check("reraise id", {28'b0, cur_id}, 32'd5);
    rd(A_PENDING, r); check("reraise pending", r, 32'h20);

    // Held line sets pending once; mask enables it later; set beats clear.
    do_reset();
    src_irq = 8'h08;
    repeat (20) step();
    rd(A_PENDING, r); check("held pending", r, 32'h08);
    check("held masked ir", {31'b0, ir_out}, 32'd0);
    wr(A_MASK, 32'h08);
    step();
    check("unmask ir", {31'b0, ir_out}, 32'd1);
    check("unmask id", {28'b0, cur_id}, 32'd3);
    src_irq = 8'h00; step(); step();
    src_irq = 8'h08; step();
    wr(A_CLAIM, 32'd3);
    rd(A_PENDING, r); check("set wins pending", r, 32'h08);
    rd(A_STATUS, r);  check("set wins status", r, 32'h3002);
    eret = 1'b1; step(); eret = 1'b0;
    step();
    check("set wins reraise", {31'b0, ir_out}, 32'd1);

    // Reset mid-request, then ignored writes and out-of-range claims.
    do_reset();
    check("midreset ir", {31'b0, ir_out}, 32'd0);
    rd(A_PENDING, r); check("midreset pending", r, 32'h0);
    rd(A_MASK, r);    check("midreset mask", r, 32'h0);
    rd(A_STATUS, r);  check("midreset status", r, 32'h0);
    src_irq = 8'h80; step();
    src_irq = 8'h00; step();
    rd(A_PENDING, r); check("bit7 pending", r, 32'h80);
    wr(A_PENDING, 32'h0);
    rd(A_PENDING, r); check("pending write ignored", r, 32'h80);
    wr(A_STATUS, 32'hFFFFFFFF);
    rd(A_STATUS, r);  check("status write ignored", r, 32'h0);
    wr(A_CLAIM, 32'd15);
    rd(A_PENDING, r); check("claim 15 no effect", r, 32'h80);
    wr(A_CLAIM, 32'd8);
    rd(A_PENDING, r); check("claim 8 no effect", r, 32'h80);
    wr(A_CLAIM, 32'd7);
    rd(A_PENDING, r); check("claim 7 clears", r, 32'h0);
    check("idle ir after claims", {31'b0, ir_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
